fir_coeff_loader: RTL and testbench
===================================

Name: fir_coeff_loader

Overview:
Transmitter side of the FIR coefficient-reload AXI-Stream interface. Host register writes fill a shadow coefficient array. A commit pulse then streams the whole set, index 0 first, onto reload_valid / reload_last / coeff under reload_ready back-pressure. Sits between the host register decode and the FIR filter wrapper. Asserting reload_valid also pauses that wrapper's channel sequencing; reload_last re-arms its config packet.

Parameters:
NUM_COEFF, 41, number of coefficients per reload packet (2..64)
COEFF_WIDTH, 16, coefficient width in bits
ADDR_WIDTH, 6, shadow-array index width; must satisfy 2**ADDR_WIDTH >= NUM_COEFF

Ports:
clkfir  in  1  FIR clock; all logic is on the rising edge
reset  in  1  synchronous, active-high reset
wr_en  in  1  host write strobe for the shadow array
wr_addr  in  ADDR_WIDTH  shadow-array index
wr_data  in  COEFF_WIDTH  coefficient value (two's complement)
commit  in  1  single-cycle request to stream the shadow array
reload_valid  out  1  AXIS tvalid toward the FIR reload port
reload_last  out  1  AXIS tlast; high on the beat carrying index NUM_COEFF-1
coeff  out  COEFF_WIDTH  AXIS tdata
reload_ready  in  1  AXIS tready from the FIR reload port
busy  out  1  high from commit acceptance until the last beat is accepted
done  out  1  one-cycle pulse after the last beat is accepted
err  out  2  sticky flags: [0] commit while busy, [1] write dropped (busy or out-of-range address)
err_clr  in  1  clears err

Behaviour:
- Reset: reload_valid=0, reload_last=0, coeff=0, busy=0, done=0, err=0, FSM=IDLE, index=0. Shadow array contents are not reset; power-up initial value is 0.
- Shadow write: when wr_en && !busy && wr_addr<NUM_COEFF, array[wr_addr]<=wr_data. Otherwise the write is dropped and err[1]<=1.
- FSM states: IDLE, SEND, FINISH.
- IDLE: on commit, set busy=1 and load coeff<=array[0]. reload_valid=1 on the next cycle. Set reload_last=(NUM_COEFF==1)? No: NUM_COEFF>=2, so reload_last=0. Set index=0 and go to SEND. Commit-to-valid latency is 1 cycle.
- SEND: a handshake is reload_valid && reload_ready.
  - While !reload_ready, hold coeff, reload_last and reload_valid stable. reload_valid never drops mid-packet.
  - On a handshake with index<NUM_COEFF-1: coeff<=array[index+1], index<=index+1, reload_last<=(index+1==NUM_COEFF-1). There is no bubble, so with reload_ready tied high the packet takes exactly NUM_COEFF cycles.
  - On a handshake with reload_last=1: reload_valid<=0, reload_last<=0, go to FINISH.
- FINISH: done=1 for one cycle, busy<=0, return to IDLE. A commit arriving in FINISH is treated as commit-while-busy.
- Commit while busy: ignored, err[0]<=1. The in-flight packet is unaffected.
- Simultaneous wr_en and commit in IDLE: the write lands and commit streams the old array[wr_addr] value for that index. The bench checks this ordering.
- err_clr wins over a same-cycle error set.
- Reset mid-packet: all outputs return to reset values on the next edge and the packet is truncated. The downstream core then flags tlast-missing, which is accepted behaviour; software re-commits.
- The coefficient array is written and read as raw bits; there is no arithmetic.

Optional Feature:
FIR_COEFF_READBACK_EN
- Defined: adds input rd_addr[ADDR_WIDTH] and output rd_data[COEFF_WIDTH]. rd_data is registered array[rd_addr], 1-cycle latency, valid in any state. Addresses >=NUM_COEFF read 0.
- Undefined: the ports are absent and no read mux is built.

Decomposition:
- Package fir_coeff_pkg holds the FSM state encoding (IDLE=2'd0, SEND=2'd1, FINISH=2'd2), the default NUM_COEFF / COEFF_WIDTH, and the err bit positions (ERR_COMMIT_BUSY=0, ERR_WR_DROP=1). These are shared with the host register map and the filter wrapper.
- One sub-module: fir_coeff_store, the shadow array with its write-port and read-mux (including the optional readback port).
- FSM and AXIS output registers stay in the top level.

Test Plan:
- Write array[i]=i*3+1 for i=0..40, commit, reload_ready=1 → reload_valid high for exactly 41 cycles starting 1 cycle after commit, coeff=1,4,...,121, reload_last only on the 121 beat, done pulse on the next cycle.
- Same load with reload_ready toggling 1/0 per cycle → coeff and reload_last stable during stalls, 41 beats over 81 cycles, no dropped or repeated index.
- Commit pulsed at beat 10 of an active packet → packet unchanged, err=2'b01; then err_clr → err=0.
- Write to wr_addr=45, and a write during busy → array unchanged (readback confirms when FIR_COEFF_READBACK_EN is defined), err[1]=1.
- Reset asserted at beat 20 → reload_valid=0, busy=0, coeff=0 next cycle; a subsequent commit streams the full 41 beats correctly.
- wr_en (addr 0, data 16'h7FFF) in the same cycle as commit with array[0]=16'h0005 → first beat coeff=16'h0005, and a second commit sends 16'h7FFF first.

Source files
------------

// File: rtl/fir_coeff_pkg.sv
// Shared definitions for the FIR coefficient-reload path: FSM encoding,
// default geometry and err bit positions used by host map and filter wrapper.
package fir_coeff_pkg;

  localparam int DEF_NUM_COEFF   = 41;
  localparam int DEF_COEFF_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH  = 6;

  localparam int ERR_COMMIT_BUSY = 0;
  localparam int ERR_WR_DROP     = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    FINISH = 2'd2
  } fir_state_t;

endpackage

// File: rtl/fir_coeff_loader_if.sv
// AXI-Stream coefficient reload channel between the loader (master) and
// the FIR filter wrapper (slave).
interface fir_coeff_loader_if #(
  parameter int COEFF_WIDTH = 16
);
  // A beat transfers on a rising edge where reload_valid && reload_ready.
  // Once valid is raised, valid/last/coeff hold until that beat transfers.
  logic                   reload_valid;
  logic                   reload_last;
  logic [COEFF_WIDTH-1:0] coeff;
  logic                   reload_ready;

  modport master (
    output reload_valid,
    output reload_last,
    output coeff,
    input  reload_ready
  );

  modport slave (
    input  reload_valid,
    input  reload_last,
    input  coeff,
    output reload_ready
  );
endinterface

// File: rtl/fir_coeff_store.sv
// Shadow coefficient array: guarded host write port, streaming read port and,
// with FIR_COEFF_READBACK_EN defined, a registered host readback port.
module fir_coeff_store
  import fir_coeff_pkg::*;
#(
  parameter int NUM_COEFF   = DEF_NUM_COEFF,
  parameter int COEFF_WIDTH = DEF_COEFF_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
  input  logic                   clkfir,
  input  logic                   wr_en,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [COEFF_WIDTH-1:0] wr_data,
  input  logic                   lock,
  output logic                   wr_drop,
  input  logic [ADDR_WIDTH-1:0]  stream_addr,
  output logic [COEFF_WIDTH-1:0] stream_data
`ifdef FIR_COEFF_READBACK_EN
  ,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [COEFF_WIDTH-1:0] rd_data
`endif
);

  localparam logic [ADDR_WIDTH:0] NUM_EXT = (ADDR_WIDTH+1)'(NUM_COEFF);

  // Deliberately unreset: software reloads the whole set after power-up.
  logic [COEFF_WIDTH-1:0] mem [NUM_COEFF];
  logic                   wr_ok;

  assign wr_ok   = wr_en && !lock && ({1'b0, wr_addr} < NUM_EXT);
  assign wr_drop = wr_en && !wr_ok;

  always_ff @(posedge clkfir) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Combinational read sees the pre-write value, so a same-cycle write
  // and commit streams the old entry.
  assign stream_data = ({1'b0, stream_addr} < NUM_EXT) ? mem[stream_addr] : '0;

`ifdef FIR_COEFF_READBACK_EN
  always_ff @(posedge clkfir) begin
    rd_data <= ({1'b0, rd_addr} < NUM_EXT) ? mem[rd_addr] : '0;
  end
`endif

endmodule

// File: rtl/fir_coeff_loader.sv
// FIR coefficient reload transmitter: streams the shadow array as one AXIS
// packet per commit. Optional readback port under FIR_COEFF_READBACK_EN.
module fir_coeff_loader
  import fir_coeff_pkg::*;
#(
  parameter int NUM_COEFF   = DEF_NUM_COEFF,
  parameter int COEFF_WIDTH = DEF_COEFF_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
  input  logic                   clkfir,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [COEFF_WIDTH-1:0] wr_data,
  input  logic                   commit,
  fir_coeff_loader_if.master     axis,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             err,
  input  logic                   err_clr,
  output fir_state_t             state
`ifdef FIR_COEFF_READBACK_EN
  ,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [COEFF_WIDTH-1:0] rd_data
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_COEFF - 1);

  fir_state_t             state_q, state_n;
  logic [ADDR_WIDTH-1:0]  index_q, index_n, index_inc;
  logic                   valid_q, valid_n;
  logic                   last_q, last_n;
  logic [COEFF_WIDTH-1:0] coeff_q, coeff_n;
  logic                   busy_q, busy_n;
  logic                   done_q, done_n;
  logic [1:0]             err_q, err_n, err_set;
  logic [ADDR_WIDTH-1:0]  stream_addr;
  logic [COEFF_WIDTH-1:0] stream_data;
  logic                   wr_drop;

  fir_coeff_store #(
    .NUM_COEFF  (NUM_COEFF),
    .COEFF_WIDTH(COEFF_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_store (
    .clkfir     (clkfir),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .lock       (busy_q),
    .wr_drop    (wr_drop),
    .stream_addr(stream_addr),
    .stream_data(stream_data)
`ifdef FIR_COEFF_READBACK_EN
    ,
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
`endif
  );

  assign index_inc = index_q + 1'b1;

  always_ff @(posedge clkfir) begin
    if (reset) begin
      state_q <= IDLE;
      index_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      coeff_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_n;
      index_q <= index_n;
      valid_q <= valid_n;
      last_q  <= last_n;
      coeff_q <= coeff_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    index_n     = index_q;
    valid_n     = valid_q;
    last_n      = last_q;
    coeff_n     = coeff_q;
    busy_n      = busy_q;
    done_n      = 1'b0;
    stream_addr = '0;

    // busy covers FINISH too, so a commit there counts as commit-while-busy.
    err_set                  = '0;
    err_set[ERR_COMMIT_BUSY] = commit && busy_q;
    err_set[ERR_WR_DROP]     = wr_drop;
    err_n                    = err_clr ? '0 : (err_q | err_set);

    case (state_q)
      IDLE: begin
        if (commit) begin
          coeff_n = stream_data;
          valid_n = 1'b1;
          last_n  = 1'b0;
          index_n = '0;
          busy_n  = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        stream_addr = index_inc;
        if (valid_q && axis.reload_ready) begin
          if (last_q) begin
            valid_n = 1'b0;
            last_n  = 1'b0;
            done_n  = 1'b1;
            state_n = FINISH;
          end else begin
            coeff_n = stream_data;
            index_n = index_inc;
            last_n  = (index_inc == LAST_IDX);
          end
        end
      end
      FINISH: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign axis.reload_valid = valid_q;
  assign axis.reload_last  = last_q;
  assign axis.coeff        = coeff_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;
  assign state             = state_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Bench for fir_coeff_loader: write/err vector table plus packet sequences
// with a beat scoreboard. Readback checks follow FIR_COEFF_READBACK_EN.
`timescale 1ns/1ps
module tb_fir_coeff_loader;
  import fir_coeff_pkg::*;

  localparam int NC = 41;
  localparam int CW = 16;
  localparam int AW = 6;

  logic          clkfir;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] wr_data;
  logic          commit;
  logic          busy;
  logic          done;
  logic [1:0]    err;
  logic          err_clr;
  fir_state_t    state;
`ifdef FIR_COEFF_READBACK_EN
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] rd_data;
`endif

  fir_coeff_loader_if #(.COEFF_WIDTH(CW)) axis ();

  fir_coeff_loader #(
    .NUM_COEFF  (NC),
    .COEFF_WIDTH(CW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clkfir (clkfir),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .commit (commit),
    .axis   (axis.master),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .err_clr(err_clr),
    .state  (state)
`ifdef FIR_COEFF_READBACK_EN
    ,
    .rd_addr(rd_addr),
    .rd_data(rd_data)
`endif
  );

  // clock / reset
  initial clkfir = 1'b0;
  always #5 clkfir = ~clkfir;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  int n_checks = 0;
  int n_errors = 0;
  int vcyc     = 0;
  int beats    = 0;

  logic [CW:0]   exp_q[$];
  logic [CW-1:0] model_mem [NC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: beats at negedge, plus hold-stable check across stalls
  logic        stall_prev = 1'b0;
  logic [CW+1:0] stall_word = '0;
  always @(negedge clkfir) begin
    logic [CW:0] e;
    if (axis.reload_valid) vcyc++;
    if (stall_prev)
      check("stall_hold", {axis.reload_valid, axis.reload_last, axis.coeff}, stall_word);
    if (axis.reload_valid && axis.reload_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {axis.reload_last, axis.coeff}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("beat%0d", beats), {axis.reload_last, axis.coeff}, e);
      end
      beats++;
    end
    stall_prev = axis.reload_valid && !axis.reload_ready;
    stall_word = {1'b1, axis.reload_last, axis.coeff};
  end

  // driver tasks
  task automatic tick();
    @(posedge clkfir);
    #1;
  endtask

  task automatic write_word(input int addr, input logic [CW-1:0] data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    tick();
    wr_en = 1'b0;
    if (addr < NC) model_mem[addr] = data;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clkfir);
    check("err_after_clr", err, 2'b00);
  endtask

  task automatic run_packet(input bit toggle, input int commit_at, input int wr_at,
                            input int rst_at, input bit wr_with_commit,
                            input int exp_vcyc, input string tag);
    int done_cyc;
    done_cyc = 0;
    for (int i = 0; i < NC; i++) exp_q.push_back({(i == NC-1), model_mem[i]});
    vcyc = 0;
    beats = 0;
    axis.reload_ready = 1'b1;
    commit  = 1'b1;
    wr_en   = wr_with_commit;
    wr_addr = '0;
    wr_data = 16'h7FFF;
    tick();
    commit = 1'b0;
    wr_en  = 1'b0;
    if (wr_with_commit) model_mem[0] = 16'h7FFF;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clkfir);
      if (n == 1) begin
        check({tag, "_commit_to_valid"}, axis.reload_valid, 1);
        check({tag, "_busy_on_commit"}, busy, 1);
      end
      if (done) begin
        done_cyc = n;
        break;
      end
      tick();
      if (n == rst_at) begin
        reset = 1'b0;
        break;
      end
      axis.reload_ready = toggle ? ~axis.reload_ready : 1'b1;
      commit  = (n + 1 == commit_at);
      wr_en   = (n + 1 == wr_at);
      wr_addr = 6'd5;
      wr_data = 16'hBEEF;
      reset   = (n + 1 == rst_at);
    end
    if (rst_at != 0) begin
      commit = 1'b0;
      wr_en  = 1'b0;
      @(negedge clkfir);
      check({tag, "_rst_valid"}, axis.reload_valid, 0);
      check({tag, "_rst_last"}, axis.reload_last, 0);
      check({tag, "_rst_coeff"}, axis.coeff, 0);
      check({tag, "_rst_busy"}, busy, 0);
      check({tag, "_rst_done"}, done, 0);
      check({tag, "_rst_state"}, state, IDLE);
      exp_q.delete();
    end else begin
      check({tag, "_done_cycle"}, done_cyc, exp_vcyc + 1);
      tick();
      commit = 1'b0;
      wr_en  = 1'b0;
      axis.reload_ready = 1'b1;
      @(negedge clkfir);
      check({tag, "_done_pulse_end"}, done, 0);
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_valid_end"}, axis.reload_valid, 0);
      check({tag, "_valid_cycles"}, vcyc, exp_vcyc);
      check({tag, "_beats"}, beats, NC);
      check({tag, "_queue_empty"}, exp_q.size(), 0);
    end
  endtask

  typedef struct {
    logic          wr_en;
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
    logic          clr;
    logic [1:0]    exp_err;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{1'b1, 6'd0,  16'h0005, 1'b0, 2'b00};
    vecs[1] = '{1'b1, 6'd40, 16'h1234, 1'b0, 2'b00};
    vecs[2] = '{1'b1, 6'd45, 16'hAAAA, 1'b0, 2'b10};
    vecs[3] = '{1'b0, 6'd0,  16'h0000, 1'b1, 2'b00};
    vecs[4] = '{1'b1, 6'd63, 16'h5555, 1'b1, 2'b00};
    vecs[5] = '{1'b1, 6'd41, 16'h0001, 1'b0, 2'b10};
    vecs[6] = '{1'b1, 6'd7,  16'h00FF, 1'b0, 2'b10};
    vecs[7] = '{1'b0, 6'd0,  16'h0000, 1'b1, 2'b00};

    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    commit  = 1'b0;
    err_clr = 1'b0;
    axis.reload_ready = 1'b1;
`ifdef FIR_COEFF_READBACK_EN
    rd_addr = '0;
`endif
    for (int i = 0; i < NC; i++) model_mem[i] = '0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clkfir);
    check("reset_valid", axis.reload_valid, 0);
    check("reset_last", axis.reload_last, 0);
    check("reset_coeff", axis.coeff, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_state", state, IDLE);

    for (int i = 0; i < 8; i++) begin
      wr_en   = vecs[i].wr_en;
      wr_addr = vecs[i].addr;
      wr_data = vecs[i].data;
      err_clr = vecs[i].clr;
      tick();
      wr_en   = 1'b0;
      err_clr = 1'b0;
      if (vecs[i].wr_en && vecs[i].addr < NC) model_mem[vecs[i].addr] = vecs[i].data;
      @(negedge clkfir);
      check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
    end

`ifdef FIR_COEFF_READBACK_EN
    rd_addr = 6'd0;  tick(); @(negedge clkfir); check("rb_addr0", rd_data, 16'h0005);
    rd_addr = 6'd40; tick(); @(negedge clkfir); check("rb_addr40", rd_data, 16'h1234);
    rd_addr = 6'd45; tick(); @(negedge clkfir); check("rb_addr45", rd_data, 16'h0000);
`endif

    for (int i = 0; i < NC; i++) write_word(i, CW'(i * 3 + 1));
    @(negedge clkfir);
    check("ramp_err", err, 0);

    run_packet(1'b0, 0, 0, 0, 1'b0, NC, "full");
    run_packet(1'b1, 0, 0, 0, 1'b0, 2 * NC - 1, "toggle");

    run_packet(1'b0, 11, 0, 0, 1'b0, NC, "commit_busy");
    check("commit_busy_err", err, 2'b01);
    clear_err();

    run_packet(1'b0, NC + 1, 0, 0, 1'b0, NC, "commit_finish");
    check("commit_finish_err", err, 2'b01);
    repeat (2) @(negedge clkfir);
    check("commit_finish_no_packet", axis.reload_valid, 0);
    clear_err();

    run_packet(1'b0, 0, 15, 0, 1'b0, NC, "wr_busy");
    check("wr_busy_err", err, 2'b10);
`ifdef FIR_COEFF_READBACK_EN
    rd_addr = 6'd5; tick(); @(negedge clkfir); check("rb_addr5_after_busy_wr", rd_data, 16'd16);
`endif
    clear_err();

    run_packet(1'b0, 0, 0, 20, 1'b0, NC, "midreset");
    run_packet(1'b0, 0, 0, 0, 1'b0, NC, "after_reset");

    write_word(0, 16'h0005);
    run_packet(1'b0, 0, 0, 0, 1'b1, NC, "wr_and_commit");
    check("wr_and_commit_err", err, 2'b00);
    run_packet(1'b0, 0, 0, 0, 1'b0, NC, "second_commit");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
